timer_keypad_ctrl: RTL and testbench

Front-end controller for the MM:SS countdown timer: a microwave-style oven controller.
- Accepts decimal key presses and shifts them into the timer one digit per `timer_load` pulse, MSB-first.
- Generates the 1 Hz count-enable strobe and sequences start/pause/clear/door interlock.
- Consumes the timer's `finished` flag and drives the heater and alarm outputs.
- Sits directly upstream of the timer and shares its `clk`/`rst`.

---
 rtl/timer_keypad_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_timer_keypad_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_keypad_ctrl.sv
// Keypad front-end for the MM:SS countdown timer (microwave-style oven controller).
// Shifts decimal keys into the timer, generates the 1 Hz count-enable strobe,
// sequences start/pause/clear/door interlock and drives heater and alarm.
// Optional key beep on accepted digits: define TIMER_CTRL_KEY_BEEP_EN.
module timer_keypad_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 100,
  parameter int unsigned ALARM_CYCLES  = 50,
  parameter int unsigned BEEP_CYCLES   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       door_closed,
  input  logic       timer_finished,
  output logic [3:0] timer_in,
  output logic       timer_load,
  output logic       timer_enablen,
  output logic       cooking,
  output logic       alarm,
  output logic [2:0] digit_count
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned AW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    COOKING = 3'd2,
    PAUSED  = 3'd3,
    CLEAR   = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [AW-1:0] alarm_cnt, alarm_cnt_nxt;
  logic [1:0]    clr_cnt, clr_cnt_nxt;
  logic [2:0]    digit_count_nxt;
  logic [3:0]    timer_in_nxt;
  logic          timer_load_nxt;
  logic          timer_enablen_nxt;
  logic          key_accept;
  logic          digit_key;
  logic          door_prev;
  logic          beep_nxt;

  assign digit_key = key_valid && (key_code <= 4'd9);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state, counters and next output values
  always_comb begin
    state_nxt         = state;
    presc_nxt         = presc;
    alarm_cnt_nxt     = '0;
    clr_cnt_nxt       = '0;
    digit_count_nxt   = digit_count;
    timer_in_nxt      = timer_in;
    timer_load_nxt    = 1'b0;
    timer_enablen_nxt = 1'b1;
    key_accept        = 1'b0;

    case (state)
      IDLE: begin
        if (digit_key) begin
          key_accept      = 1'b1;
          digit_count_nxt = 3'd1;
          state_nxt       = ENTRY;
        end
      end
      ENTRY: begin
        // A key in the same cycle as start always wins over start
        if (stop_clear) begin
          state_nxt = CLEAR;
        end else if (key_valid) begin
          if (digit_key && (digit_count < 3'd4)) begin
            key_accept      = 1'b1;
            digit_count_nxt = digit_count + 3'd1;
          end
        end else if (start && door_closed && !timer_finished) begin
          presc_nxt = '0;
          state_nxt = COOKING;
        end
      end
      COOKING: begin
        // Finished has priority so completion is never lost to a pause
        if (timer_finished) begin
          state_nxt = DONE;
        end else if (!door_closed || stop_clear) begin
          state_nxt = PAUSED;
        end else if (presc == PW'(TICKS_PER_SEC - 1)) begin
          presc_nxt         = '0;
          timer_enablen_nxt = 1'b0;
        end else begin
          presc_nxt = presc + PW'(1);
        end
      end
      PAUSED: begin
        if (stop_clear)                state_nxt = CLEAR;
        else if (start && door_closed) state_nxt = COOKING;
      end
      CLEAR: begin
        // Four zero shifts flush every timer digit
        timer_load_nxt = 1'b1;
        timer_in_nxt   = 4'd0;
        clr_cnt_nxt    = clr_cnt + 2'd1;
        if (clr_cnt == 2'd3) begin
          digit_count_nxt = 3'd0;
          state_nxt       = IDLE;
        end
      end
      DONE: begin
        alarm_cnt_nxt = alarm_cnt + AW'(1);
        if ((alarm_cnt == AW'(ALARM_CYCLES - 1)) || stop_clear ||
            (door_prev && !door_closed)) begin
          alarm_cnt_nxt   = '0;
          digit_count_nxt = 3'd0;
          state_nxt       = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (key_accept) begin
      timer_load_nxt = 1'b1;
      timer_in_nxt   = key_code;
    end
  end

`ifdef TIMER_CTRL_KEY_BEEP_EN
  localparam int unsigned BW = $clog2(BEEP_CYCLES + 1);
  logic [BW-1:0] beep_cnt, beep_cnt_nxt;

  // Beep length counter, restarted by every accepted digit
  always_comb begin
    beep_cnt_nxt = beep_cnt;
    if (key_accept)            beep_cnt_nxt = BW'(BEEP_CYCLES);
    else if (beep_cnt != '0)   beep_cnt_nxt = beep_cnt - BW'(1);
  end

  // Beep counter register
  always_ff @(posedge clk) begin
    if (rst) beep_cnt <= '0;
    else     beep_cnt <= beep_cnt_nxt;
  end

  assign beep_nxt = (beep_cnt_nxt != '0);
`else
  logic unused_beep;
  assign unused_beep = (BEEP_CYCLES != 0);
  assign beep_nxt    = 1'b0;
`endif

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      presc         <= '0;
      alarm_cnt     <= '0;
      clr_cnt       <= '0;
      door_prev     <= 1'b0;
      digit_count   <= 3'd0;
      timer_in      <= 4'd0;
      timer_load    <= 1'b0;
      timer_enablen <= 1'b1;
      cooking       <= 1'b0;
      alarm         <= 1'b0;
    end else begin
      presc         <= presc_nxt;
      alarm_cnt     <= alarm_cnt_nxt;
      clr_cnt       <= clr_cnt_nxt;
      door_prev     <= door_closed;
      digit_count   <= digit_count_nxt;
      timer_in      <= timer_in_nxt;
      timer_load    <= timer_load_nxt;
      timer_enablen <= timer_enablen_nxt;
      cooking       <= (state_nxt == COOKING);
      alarm         <= (state_nxt == DONE) || beep_nxt;
    end
  end

endmodule

// File: tb/tb_timer_keypad_ctrl.sv
// Self-checking bench for timer_keypad_ctrl with a BCD MM:SS timer model.
// Honours TIMER_CTRL_KEY_BEEP_EN for the key-beep checks.
module tb_timer_keypad_ctrl;

  localparam int TICKS = 100;
  localparam int ALARM = 50;
  localparam int BEEP  = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic        start = 1'b0;
  logic        stop_clear = 1'b0;
  logic        door_closed = 1'b1;
  logic        timer_finished;
  logic [3:0]  timer_in;
  logic        timer_load;
  logic        timer_enablen;
  logic        cooking;
  logic        alarm;
  logic [2:0]  digit_count;

  logic [15:0] tm;
  logic [3:0]  exp_q[$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  timer_keypad_ctrl #(
    .TICKS_PER_SEC(TICKS),
    .ALARM_CYCLES (ALARM),
    .BEEP_CYCLES  (BEEP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .start         (start),
    .stop_clear    (stop_clear),
    .door_closed   (door_closed),
    .timer_finished(timer_finished),
    .timer_in      (timer_in),
    .timer_load    (timer_load),
    .timer_enablen (timer_enablen),
    .cooking       (cooking),
    .alarm         (alarm),
    .digit_count   (digit_count)
  );

  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] m10, m1, s10, s1;
    {m10, m1, s10, s1} = t;
    if (s1 != 4'd0) s1 = s1 - 4'd1;
    else begin
      s1 = 4'd9;
      if (s10 != 4'd0) s10 = s10 - 4'd1;
      else begin
        s10 = 4'd5;
        if (m1 != 4'd0) m1 = m1 - 4'd1;
        else begin
          m1  = 4'd9;
          m10 = m10 - 4'd1;
        end
      end
    end
    return {m10, m1, s10, s1};
  endfunction

  // Downstream timer model: shift-load and BCD countdown
  always @(posedge clk) begin
    if (rst)                                  tm <= 16'h0000;
    else if (timer_load)                      tm <= {tm[11:0], timer_in};
    else if (!timer_enablen && tm != 16'h0000) tm <= bcd_dec(tm);
  end
  assign timer_finished = (tm == 16'h0000);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every load pulse must match the oldest expected digit
  always @(negedge clk) begin
    if (!rst && timer_load) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_load: timer_in=%0d with no load expected", timer_in);
      end else begin
        chk("load_digit", int'(timer_in), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] code, input logic ld);
    key_valid = 1'b1;
    key_code  = code;
    if (ld) exp_q.push_back(code);
    tick();
    key_valid = 1'b0;
    tick();
  endtask

  task automatic do_clear();
    stop_clear = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(4'd0);
    tick();
    stop_clear = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("clear_digit_count", int'(digit_count), 0);
    tick();
    chk("clear_timer", int'(tm), 0);
  endtask

  typedef struct {
    logic       kv;
    logic [3:0] kc;
    logic       st;
    logic       sc;
    logic       dc;
    logic       ld;
    logic [2:0] dcnt;
    logic       cook;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int k;
    int strobes;
    int bad;
    int first_gap;
    int cnt;

    vecs[0]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0}; // start, nothing entered
    vecs[1]  = '{1'b1, 4'd12, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0}; // non-digit in IDLE
    vecs[2]  = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0}; // stop_clear in IDLE
    vecs[3]  = '{1'b1, 4'd1,  1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0}; // key 1
    vecs[4]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0};
    vecs[5]  = '{1'b1, 4'd2,  1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0}; // key wins over start
    vecs[6]  = '{1'b1, 4'd3,  1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0};
    vecs[7]  = '{1'b1, 4'd12, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0}; // non-digit in ENTRY
    vecs[8]  = '{1'b1, 4'd4,  1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0};
    vecs[9]  = '{1'b1, 4'd5,  1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0}; // fifth digit ignored
    vecs[10] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0}; // start, door open
    vecs[11] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0};

    // Reset values
    repeat (3) tick();
    chk("rst_timer_in", int'(timer_in), 0);
    chk("rst_timer_load", int'(timer_load), 0);
    chk("rst_enablen", int'(timer_enablen), 1);
    chk("rst_cooking", int'(cooking), 0);
    chk("rst_alarm", int'(alarm), 0);
    chk("rst_digit_count", int'(digit_count), 0);
    rst = 1'b0;
    tick();

    // Table-driven key entry
    for (int i = 0; i < 12; i++) begin
      key_valid   = vecs[i].kv;
      key_code    = vecs[i].kc;
      start       = vecs[i].st;
      stop_clear  = vecs[i].sc;
      door_closed = vecs[i].dc;
      if (vecs[i].ld) exp_q.push_back(vecs[i].kc);
      tick();
      chk($sformatf("vec%0d_digit_count", i), int'(digit_count), int'(vecs[i].dcnt));
      chk($sformatf("vec%0d_cooking", i), int'(cooking), int'(vecs[i].cook));
      chk($sformatf("vec%0d_enablen", i), int'(timer_enablen), 1);
    end
    key_valid = 1'b0; start = 1'b0; stop_clear = 1'b0; door_closed = 1'b1;
    tick();
    chk("timer_1234", int'(tm), int'(16'h1234));
    do_clear();

    // 01:30 full cook to completion
    press(4'd1, 1'b1);
    press(4'd3, 1'b1);
    press(4'd0, 1'b1);
    chk("cook_digit_count", int'(digit_count), 3);
    chk("timer_0130", int'(tm), int'(16'h0130));
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("cook_start", int'(cooking), 1);
    k = 0; strobes = 0; bad = 0; first_gap = 0;
    for (int i = 0; i < 9500 && cooking; i++) begin
      tick();
      k++;
      if (!timer_enablen) begin
        strobes++;
        if (strobes == 1) first_gap = k;
        else if (k != TICKS) bad++;
        k = 0;
      end
    end
    chk("cook_ended", int'(cooking), 0);
    chk("first_strobe_gap", first_gap, TICKS);
    chk("bad_strobe_gaps", bad, 0);
    chk("strobe_count", strobes, 90);
    chk("done_alarm_on", int'(alarm), 1);
    cnt = 0;
    for (int i = 0; i < 200 && alarm; i++) begin
      cnt++;
      tick();
    end
    chk("alarm_cycles", cnt, ALARM);
    chk("done_digit_count", int'(digit_count), 0);

    // Door-open pause and resume
    press(4'd1, 1'b1);
    press(4'd0, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("pause_cook_start", int'(cooking), 1);
    repeat (40) tick();
    door_closed = 1'b0;
    tick();
    chk("pause_cooking_off", int'(cooking), 0);
    strobes = 0;
    for (int i = 0; i < 30; i++) begin
      start = (i >= 10 && i < 15);
      tick();
      if (!timer_enablen) strobes++;
    end
    start = 1'b0;
    chk("pause_no_strobes", strobes, 0);
    chk("pause_start_door_open", int'(cooking), 0);
    door_closed = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("resume_cooking", int'(cooking), 1);
    k = 0;
    for (int i = 0; i < 200 && timer_enablen; i++) begin
      tick();
      k++;
    end
    chk("resume_strobe_gap", k, 60);

    // Reset mid-cook
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("midrst_cooking", int'(cooking), 0);
    chk("midrst_enablen", int'(timer_enablen), 1);
    chk("midrst_alarm", int'(alarm), 0);
    chk("midrst_digit_count", int'(digit_count), 0);
    rst = 1'b0;
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    chk("idle_start_ignored", int'(cooking), 0);
    press(4'd7, 1'b1);
    chk("idle_key_digit_count", int'(digit_count), 1);

    // Key beep (alarm only in DONE when the beep is not built in)
    key_valid = 1'b1; key_code = 4'd3; exp_q.push_back(4'd3);
    tick();
    key_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (alarm) cnt++;
      tick();
    end
`ifdef TIMER_CTRL_KEY_BEEP_EN
    chk("beep_cycles", cnt, BEEP);
`else
    chk("no_beep", cnt, 0);
`endif
    key_valid = 1'b1; key_code = 4'd12;
    tick();
    key_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (alarm) cnt++;
      tick();
    end
    chk("ignored_key_no_beep", cnt, 0);
    chk("beep_digit_count", int'(digit_count), 2);

    // Keys 4,5 then clear from ENTRY
    press(4'd4, 1'b1);
    press(4'd5, 1'b1);
    chk("timer_7345", int'(tm), int'(16'h7345));
    chk("full_digit_count", int'(digit_count), 4);
    do_clear();

    // DONE left early with stop_clear
    press(4'd2, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 400 && cooking; i++) tick();
    chk("short_cook_done", int'(alarm), 1);
    repeat (5) tick();
    stop_clear = 1'b1;
    tick();
    stop_clear = 1'b0;
    chk("done_stop_alarm_off", int'(alarm), 0);
    chk("done_stop_digit_count", int'(digit_count), 0);

    tick();
    chk("pending_loads", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
